// File: rtl/cache_axi_arbiter_pkg.sv
// Shared definitions for the cache-to-AXI-bridge arbiter: read FSM encoding,
// read request type codes and grant identifiers.
package cache_axi_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        I_REQ  = 3'd1,
        I_WAIT = 3'd2,
        D_REQ  = 3'd3,
        D_WAIT = 3'd4
    } rd_state_t;

    localparam logic [2:0] RD_TYPE_LINE = 3'b100;

    // Grant identifiers double as the rr_arb2 request bit index.
    localparam logic GRANT_IC = 1'b0;
    localparam logic GRANT_DC = 1'b1;

endpackage

// File: rtl/cache_axi_arbiter_rr_arb2.sv
// Two-requester round-robin picker: on a tie the requester that was not
// granted last time wins; otherwise the sole requester is picked.
module rr_arb2
    import cache_axi_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       grant
);

    always_comb begin
        grant = GRANT_IC;
        if (req == 2'b11) begin
            grant = ~last;
        end else if (req[GRANT_DC]) begin
            grant = GRANT_DC;
        end
    end

endmodule

// File: rtl/cache_axi_arbiter.sv
// Shares the AXI bridge cache port between ICache and DCache: round-robin read
// arbitration held for a whole burst, plus one outstanding DCache write with a
// same-line read hazard block.
module cache_axi_arbiter
    import cache_axi_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int LINE_OFF = 4,
    parameter int DATA_W   = 32
) (
    input  logic              clk,
    input  logic              resetn,

    input  logic              ic_rd_req,
    input  logic [2:0]        ic_rd_type,
    input  logic [ADDR_W-1:0] ic_rd_addr,
    output logic              ic_rd_rdy,
    output logic              ic_ret_valid,
    output logic              ic_ret_last,
    output logic [DATA_W-1:0] ic_ret_data,

    input  logic              dc_rd_req,
    input  logic [2:0]        dc_rd_type,
    input  logic [ADDR_W-1:0] dc_rd_addr,
    output logic              dc_rd_rdy,
    output logic              dc_ret_valid,
    output logic              dc_ret_last,
    output logic [DATA_W-1:0] dc_ret_data,

    input  logic              dc_wr_req,
    input  logic [2:0]        dc_wr_type,
    input  logic [ADDR_W-1:0] dc_wr_addr,
    input  logic [3:0]        dc_wr_wstrb,
    input  logic [127:0]      dc_wr_data,
    output logic              dc_wr_rdy,
    output logic              dc_wr_resp,

    output logic              br_rd_req,
    output logic [2:0]        br_rd_type,
    output logic [ADDR_W-1:0] br_rd_addr,
    input  logic              br_rd_rdy,
    input  logic              br_ret_valid,
    input  logic              br_ret_last,
    input  logic [DATA_W-1:0] br_ret_data,

    output logic              br_wr_req,
    output logic [2:0]        br_wr_type,
    output logic [ADDR_W-1:0] br_wr_addr,
    output logic [3:0]        br_wr_wstrb,
    output logic [127:0]      br_wr_data,
    input  logic              br_wr_rdy,
    input  logic              br_wr_resp
);

    localparam int TAG_W = ADDR_W - LINE_OFF;

    rd_state_t          state_reg;
    logic               last_grant_reg;
    logic               wr_pend_reg;
    logic [TAG_W-1:0]   wr_line_reg;

    logic [1:0]         rd_elig;
    logic               arb_grant;
    logic               wr_accept;
    logic               in_i_req, in_d_req, in_i_wait, in_d_wait;

    // A read is held back only while a write to its own cache line is pending.
    assign rd_elig[GRANT_IC] = ic_rd_req &
        ~(wr_pend_reg & (ic_rd_addr[ADDR_W-1:LINE_OFF] == wr_line_reg));
    assign rd_elig[GRANT_DC] = dc_rd_req &
        ~(wr_pend_reg & (dc_rd_addr[ADDR_W-1:LINE_OFF] == wr_line_reg));

    rr_arb2 u_rr_arb2 (
        .req   (rd_elig),
        .last  (last_grant_reg),
        .grant (arb_grant)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg      <= IDLE;
            last_grant_reg <= GRANT_DC;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (|rd_elig) begin
                        state_reg      <= (arb_grant == GRANT_DC) ? D_REQ : I_REQ;
                        last_grant_reg <= arb_grant;
                    end
                end
                I_REQ:  if (br_rd_rdy) state_reg <= I_WAIT;
                D_REQ:  if (br_rd_rdy) state_reg <= D_WAIT;
                I_WAIT, D_WAIT: begin
                    if (br_ret_valid && br_ret_last) state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign wr_accept = br_wr_req & br_wr_rdy;

    // Acceptance takes priority over a (stray) response in the same cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_pend_reg <= 1'b0;
            wr_line_reg <= '0;
        end else if (wr_accept) begin
            wr_pend_reg <= 1'b1;
            wr_line_reg <= dc_wr_addr[ADDR_W-1:LINE_OFF];
        end else if (br_wr_resp) begin
            wr_pend_reg <= 1'b0;
        end
    end

    assign in_i_req  = (state_reg == I_REQ);
    assign in_d_req  = (state_reg == D_REQ);
    assign in_i_wait = (state_reg == I_WAIT);
    assign in_d_wait = (state_reg == D_WAIT);

    assign br_rd_req  = in_i_req | in_d_req;
    assign br_rd_type = in_i_req ? ic_rd_type : (in_d_req ? dc_rd_type : 3'd0);
    assign br_rd_addr = in_i_req ? ic_rd_addr : (in_d_req ? dc_rd_addr : '0);
    assign ic_rd_rdy  = in_i_req & br_rd_rdy;
    assign dc_rd_rdy  = in_d_req & br_rd_rdy;

    assign ic_ret_valid = in_i_wait & br_ret_valid;
    assign ic_ret_last  = in_i_wait & br_ret_last;
    assign ic_ret_data  = in_i_wait ? br_ret_data : '0;
    assign dc_ret_valid = in_d_wait & br_ret_valid;
    assign dc_ret_last  = in_d_wait & br_ret_last;
    assign dc_ret_data  = in_d_wait ? br_ret_data : '0;

    // Write-side pass-through is gated by resetn so nothing leaks out in reset.
    assign br_wr_req   = resetn & dc_wr_req & ~wr_pend_reg;
    assign br_wr_type  = resetn ? dc_wr_type  : 3'd0;
    assign br_wr_addr  = resetn ? dc_wr_addr  : '0;
    assign br_wr_wstrb = resetn ? dc_wr_wstrb : 4'd0;
    assign br_wr_data  = resetn ? dc_wr_data  : 128'd0;
    assign dc_wr_rdy   = resetn & br_wr_rdy & ~wr_pend_reg;
    assign dc_wr_resp  = resetn & br_wr_resp;

endmodule

// File: tb/tb_cache_axi_arbiter.sv
// Directed bench for cache_axi_arbiter: arbitration, bursts, write hazard,
// bridge stalls and reset in the middle of a burst.
module tb_cache_axi_arbiter;
    import cache_axi_pkg::*;

    logic         clk = 1'b0;
    logic         resetn;
    logic         ic_rd_req, dc_rd_req, dc_wr_req;
    logic [2:0]   ic_rd_type, dc_rd_type, dc_wr_type;
    logic [31:0]  ic_rd_addr, dc_rd_addr, dc_wr_addr;
    logic         ic_rd_rdy, ic_ret_valid, ic_ret_last;
    logic [31:0]  ic_ret_data, dc_ret_data;
    logic         dc_rd_rdy, dc_ret_valid, dc_ret_last;
    logic [3:0]   dc_wr_wstrb, br_wr_wstrb;
    logic [127:0] dc_wr_data, br_wr_data;
    logic         dc_wr_rdy, dc_wr_resp;
    logic         br_rd_req, br_rd_rdy, br_ret_valid, br_ret_last;
    logic [2:0]   br_rd_type, br_wr_type;
    logic [31:0]  br_rd_addr, br_ret_data, br_wr_addr;
    logic         br_wr_req, br_wr_rdy, br_wr_resp;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cache_axi_arbiter dut (
        .clk(clk), .resetn(resetn),
        .ic_rd_req(ic_rd_req), .ic_rd_type(ic_rd_type), .ic_rd_addr(ic_rd_addr),
        .ic_rd_rdy(ic_rd_rdy), .ic_ret_valid(ic_ret_valid), .ic_ret_last(ic_ret_last),
        .ic_ret_data(ic_ret_data),
        .dc_rd_req(dc_rd_req), .dc_rd_type(dc_rd_type), .dc_rd_addr(dc_rd_addr),
        .dc_rd_rdy(dc_rd_rdy), .dc_ret_valid(dc_ret_valid), .dc_ret_last(dc_ret_last),
        .dc_ret_data(dc_ret_data),
        .dc_wr_req(dc_wr_req), .dc_wr_type(dc_wr_type), .dc_wr_addr(dc_wr_addr),
        .dc_wr_wstrb(dc_wr_wstrb), .dc_wr_data(dc_wr_data), .dc_wr_rdy(dc_wr_rdy),
        .dc_wr_resp(dc_wr_resp),
        .br_rd_req(br_rd_req), .br_rd_type(br_rd_type), .br_rd_addr(br_rd_addr),
        .br_rd_rdy(br_rd_rdy), .br_ret_valid(br_ret_valid), .br_ret_last(br_ret_last),
        .br_ret_data(br_ret_data),
        .br_wr_req(br_wr_req), .br_wr_type(br_wr_type), .br_wr_addr(br_wr_addr),
        .br_wr_wstrb(br_wr_wstrb), .br_wr_data(br_wr_data), .br_wr_rdy(br_wr_rdy),
        .br_wr_resp(br_wr_resp)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Entered with the FSM in x_REQ; completes handshake and an nbeats burst
    // whose beat b carries mult*(b+1). Ends in the following IDLE cycle.
    task automatic do_read(input logic is_dc, input logic [31:0] addr,
                           input int nbeats, input logic [31:0] mult);
        chk("rd_req_up", br_rd_req, 1'b1);
        chk("rd_addr", br_rd_addr, addr);
        br_rd_rdy = 1'b1;
        #1;
        chk("own_rdy", is_dc ? dc_rd_rdy : ic_rd_rdy, 1'b1);
        chk("other_rdy", is_dc ? ic_rd_rdy : dc_rd_rdy, 1'b0);
        cyc();
        br_rd_rdy = 1'b0;
        if (is_dc) dc_rd_req = 1'b0; else ic_rd_req = 1'b0;
        for (int b = 0; b < nbeats; b++) begin
            br_ret_valid = 1'b1;
            br_ret_last  = (b == nbeats - 1);
            br_ret_data  = mult * (b + 1);
            #1;
            chk("own_ret_valid", is_dc ? dc_ret_valid : ic_ret_valid, 1'b1);
            chk("own_ret_data", is_dc ? dc_ret_data : ic_ret_data, mult * (b + 1));
            chk("own_ret_last", is_dc ? dc_ret_last : ic_ret_last, (b == nbeats - 1));
            chk("other_ret_valid", is_dc ? ic_ret_valid : dc_ret_valid, 1'b0);
            chk("other_ret_data", is_dc ? ic_ret_data : dc_ret_data, 32'd0);
            cyc();
        end
        br_ret_valid = 1'b0;
        br_ret_last  = 1'b0;
        br_ret_data  = '0;
        #1;
        chk("idle_after_burst", br_rd_req, 1'b0);
        $display("read done: port=%s addr=%08h beats=%0d", is_dc ? "DC" : "IC", addr, nbeats);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0;
        ic_rd_req = 0; ic_rd_type = 0; ic_rd_addr = 0;
        dc_rd_req = 0; dc_rd_type = 0; dc_rd_addr = 0;
        dc_wr_req = 1; dc_wr_type = 3'b100; dc_wr_addr = 32'h1234_5670;
        dc_wr_wstrb = 4'hF; dc_wr_data = 128'hDEAD_BEEF;
        br_rd_rdy = 1; br_ret_valid = 0; br_ret_last = 0; br_ret_data = 0;
        br_wr_rdy = 1; br_wr_resp = 0;

        // Outputs quiet in reset even with requests/ready active.
        ic_rd_req = 1;
        cyc(); cyc();
        chk("rst_br_rd_req", br_rd_req, 1'b0);
        chk("rst_ic_rd_rdy", ic_rd_rdy, 1'b0);
        chk("rst_br_wr_req", br_wr_req, 1'b0);
        chk("rst_dc_wr_rdy", dc_wr_rdy, 1'b0);
        chk("rst_br_wr_addr", br_wr_addr, 32'd0);
        $display("reset state checked");
        ic_rd_req = 0; dc_wr_req = 0; br_rd_rdy = 0;
        resetn = 1'b1;
        cyc();

        // Tie after reset: ICache first, then DCache, then alternate again.
        ic_rd_req = 1; ic_rd_addr = 32'h0000_0100;
        dc_rd_req = 1; dc_rd_addr = 32'h0000_0200;
        #1;
        chk("tie_registered", br_rd_req, 1'b0);
        cyc();
        do_read(1'b0, 32'h0000_0100, 1, 32'h5A);
        cyc();
        do_read(1'b1, 32'h0000_0200, 1, 32'hA5);
        ic_rd_req = 1; ic_rd_addr = 32'h0000_0300;
        dc_rd_req = 1; dc_rd_addr = 32'h0000_0400;
        cyc();
        do_read(1'b0, 32'h0000_0300, 1, 32'h3C);
        cyc();
        do_read(1'b1, 32'h0000_0400, 1, 32'hC3);

        // ICache-only line read.
        ic_rd_req = 1; ic_rd_type = RD_TYPE_LINE; ic_rd_addr = 32'h1FC0_0000;
        #1;
        chk("ic_line_latency", br_rd_req, 1'b0);
        cyc();
        chk("ic_line_type", br_rd_type, RD_TYPE_LINE);
        do_read(1'b0, 32'h1FC0_0000, 4, 32'h11);

        // Write accepted, then a same-line DCache read is blocked.
        dc_wr_req = 1; dc_wr_addr = 32'h8000_0040; dc_wr_data = 128'h0102_0304_0506_0708;
        br_wr_rdy = 1;
        #1;
        chk("wr_br_req", br_wr_req, 1'b1);
        chk("wr_dc_rdy", dc_wr_rdy, 1'b1);
        chk("wr_addr_pass", br_wr_addr, 32'h8000_0040);
        chk("wr_data_pass", br_wr_data, 128'h0102_0304_0506_0708);
        cyc();
        dc_wr_req = 0;
        dc_rd_req = 1; dc_rd_addr = 32'h8000_004C; dc_rd_type = 3'b000;
        cyc();
        chk("hazard_block1", br_rd_req, 1'b0);
        ic_rd_req = 1; ic_rd_addr = 32'h8000_0050; ic_rd_type = 3'b000;
        cyc();
        do_read(1'b0, 32'h8000_0050, 1, 32'h77);
        cyc();
        chk("hazard_block2", br_rd_req, 1'b0);
        br_wr_resp = 1;
        #1;
        chk("wr_resp_pass", dc_wr_resp, 1'b1);
        cyc();
        br_wr_resp = 0;
        #1;
        chk("wr_resp_pulse", dc_wr_resp, 1'b0);
        chk("hazard_grant_cycle", br_rd_req, 1'b0);
        cyc();
        do_read(1'b1, 32'h8000_004C, 1, 32'h99);

        // Second write waits for the first one's response.
        dc_wr_req = 1; dc_wr_addr = 32'h9000_0000;
        #1;
        chk("wrA_rdy", dc_wr_rdy, 1'b1);
        cyc();
        dc_wr_addr = 32'h9000_0010;
        #1;
        chk("wrB_rdy_blocked", dc_wr_rdy, 1'b0);
        chk("wrB_req_blocked", br_wr_req, 1'b0);
        cyc();
        chk("wrB_still_blocked", br_wr_req, 1'b0);
        br_wr_resp = 1;
        #1;
        chk("wrB_blocked_on_resp", dc_wr_rdy, 1'b0);
        cyc();
        br_wr_resp = 0;
        #1;
        chk("wrB_req", br_wr_req, 1'b1);
        chk("wrB_rdy", dc_wr_rdy, 1'b1);
        chk("wrB_addr", br_wr_addr, 32'h9000_0010);
        $display("second write accepted after response");
        cyc();
        dc_wr_req = 0;
        br_wr_resp = 1;
        cyc();
        br_wr_resp = 0;

        // Bridge stalls D_REQ for 3 cycles.
        dc_rd_req = 1; dc_rd_addr = 32'h0000_0040;
        cyc();
        for (int i = 0; i < 3; i++) begin
            chk("stall_req", br_rd_req, 1'b1);
            chk("stall_addr", br_rd_addr, 32'h0000_0040);
            chk("stall_rdy", dc_rd_rdy, 1'b0);
            cyc();
        end
        do_read(1'b1, 32'h0000_0040, 1, 32'h42);

        // Reset during the 2nd beat of an ICache burst with a write pending.
        dc_wr_req = 1; dc_wr_addr = 32'hA000_0000;
        #1;
        chk("pre_rst_wr_rdy", dc_wr_rdy, 1'b1);
        cyc();
        dc_wr_req = 0;
        ic_rd_req = 1; ic_rd_type = RD_TYPE_LINE; ic_rd_addr = 32'h1FC0_0000;
        cyc();
        br_rd_rdy = 1;
        cyc();
        br_rd_rdy = 0; ic_rd_req = 0;
        br_ret_valid = 1; br_ret_data = 32'h11;
        cyc();
        br_ret_data = 32'h22;
        #1;
        chk("beat2_valid", ic_ret_valid, 1'b1);
        resetn = 1'b0;
        #1;
        chk("midrst_ret_valid", ic_ret_valid, 1'b0);
        chk("midrst_ret_data", ic_ret_data, 32'd0);
        chk("midrst_br_rd_req", br_rd_req, 1'b0);
        cyc();
        br_ret_valid = 0; br_ret_data = 0;
        resetn = 1'b1;
        #1;
        chk("postrst_idle", br_rd_req, 1'b0);
        br_ret_valid = 1;
        #1;
        chk("stray_ret_ignored", ic_ret_valid, 1'b0);
        br_ret_valid = 0;
        dc_wr_req = 1; dc_wr_addr = 32'hB000_0000;
        #1;
        chk("postrst_wr_pend_clear", dc_wr_rdy, 1'b1);
        cyc();
        dc_wr_req = 0;
        ic_rd_req = 1;
        cyc();
        do_read(1'b0, 32'h1FC0_0000, 4, 32'h11);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cache_axi_arbiter.md
Name: cache_axi_arbiter

Overview:
- Shares the single cache-side port of the AXI bridge between ICache (read-only) and DCache (read and write).
- Arbitrates read requests round-robin and holds the grant until the burst's last beat returns.
- Allows one outstanding write and blocks any read that targets the cache line of a pending write, until that write's response arrives.
- Sits between the ICache/DCache miss logic and the AXI bridge.

Parameters:
- ADDR_W, 32, address width.
- LINE_OFF, 4, byte-offset bits per cache line; hazard compare uses addr[ADDR_W-1:LINE_OFF].
- DATA_W, 32, beat width of returned read data.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous, active-low reset
- ic_rd_req  in  1  ICache read request; held until ic_rd_rdy
- ic_rd_type  in  3  3'b100 = line (4 beats), else single
- ic_rd_addr  in  ADDR_W  read address
- ic_rd_rdy  out  1  request accepted this cycle
- ic_ret_valid  out  1  return beat valid
- ic_ret_last  out  1  last return beat
- ic_ret_data  out  DATA_W  return data
- dc_rd_req, dc_rd_type, dc_rd_addr, dc_rd_rdy, dc_ret_valid, dc_ret_last, dc_ret_data  (same directions and widths as the ic_ signals)  DCache read port
- dc_wr_req  in  1  DCache write request; held until dc_wr_rdy
- dc_wr_type  in  3  write type
- dc_wr_addr  in  ADDR_W  write address
- dc_wr_wstrb  in  4  byte strobe
- dc_wr_data  in  128  line data
- dc_wr_rdy  out  1  write accepted this cycle
- dc_wr_resp  out  1  write completed (pulse)
- br_rd_req  out  1  to bridge
- br_rd_type  out  3  to bridge
- br_rd_addr  out  ADDR_W  to bridge
- br_rd_rdy  in  1  from bridge
- br_ret_valid  in  1  from bridge
- br_ret_last  in  1  from bridge
- br_ret_data  in  DATA_W  from bridge
- br_wr_req  out  1  to bridge
- br_wr_type  out  3  to bridge
- br_wr_addr  out  ADDR_W  to bridge
- br_wr_wstrb  out  4  to bridge
- br_wr_data  out  128  to bridge
- br_wr_rdy  in  1  from bridge
- br_wr_resp  in  1  from bridge

Behaviour:
- Reset:
  - Clock is clk; reset is resetn, asynchronous, active-low.
  - On reset: read FSM = IDLE, last_grant = DC (so ICache wins the first tie), wr_pend = 0, wr_line = 0.
  - All request outputs and all rdy/ret outputs are 0 while in reset.
  - Reset mid-burst abandons the burst silently; no ret pulses are issued.
- Read FSM states: IDLE, I_REQ, I_WAIT, D_REQ, D_WAIT.
- Eligibility: a read is eligible when its req=1 and, if wr_pend=1, its addr[ADDR_W-1:LINE_OFF] != wr_line.
- IDLE:
  - Only ICache eligible -> I_REQ.
  - Only DCache eligible -> D_REQ.
  - Both eligible -> the one not equal to last_grant.
  - A grant updates last_grant.
  - The grant decision is registered: one cycle from req to br_rd_req.
- x_REQ:
  - br_rd_req=1; br_rd_type/br_rd_addr are passed through combinationally from the granted requester.
  - x_rd_rdy = br_rd_rdy.
  - When br_rd_rdy=1 -> x_WAIT.
- x_WAIT:
  - br_ret_valid/last/data are routed to the granted port only; the other port's ret_valid/ret_last stay 0 and its ret_data stays 0.
  - br_ret_valid & br_ret_last -> IDLE.
  - A new grant can be issued in the IDLE cycle that follows, so back-to-back grants have a minimum 1-cycle gap.
- Non-granted requester: its rdy stays 0 and it keeps holding its request.
- Write path:
  - br_wr_req = dc_wr_req & ~wr_pend.
  - The other br_wr_* outputs are passed through from the dc_wr_* inputs.
  - dc_wr_rdy = br_wr_rdy & ~wr_pend.
  - On acceptance (br_wr_req & br_wr_rdy): wr_pend <= 1 and wr_line <= dc_wr_addr[ADDR_W-1:LINE_OFF].
  - On br_wr_resp: wr_pend <= 0; dc_wr_resp = br_wr_resp.
  - br_wr_resp and a new acceptance in the same cycle are impossible because acceptance requires ~wr_pend. If both occur, acceptance wins and wr_pend stays 1.
  - Writes proceed independently of the read FSM.
- Hazard timing: the hazard check is evaluated only in IDLE. A read granted before a same-line write was accepted is not revoked; the DCache orders these itself.
- Bridge misbehaviour: br_ret_valid outside x_WAIT is ignored. br_wr_resp with wr_pend=0 is passed through to dc_wr_resp with no state change.

Decomposition:
- Package cache_axi_pkg: read-state encoding (IDLE=3'd0, I_REQ=3'd1, I_WAIT=3'd2, D_REQ=3'd3, D_WAIT=3'd4), RD_TYPE_LINE=3'b100, GRANT_IC/GRANT_DC constants.
- One sub-module, rr_arb2: 2-requester round-robin picker with inputs req[1:0], last, and output grant.

Test Plan:
- ICache-only line read at 0x1FC0_0000: ic_rd_req held -> br_rd_req rises 1 cycle later; 4 ic_ret_valid beats with data 0x11,0x22,0x33,0x44; ic_ret_last on the 4th; dc_ret_valid stays 0.
- ic_rd_req and dc_rd_req rise in the same cycle after reset -> ICache granted first; DCache granted in the IDLE cycle after ICache's last beat; a second tie -> ICache again (alternation).
- DCache write to 0x8000_0040 accepted, then dc_rd_req to 0x8000_004C -> no grant until br_wr_resp; the grant appears in the cycle after the resp. A read to 0x8000_0050 in the same window is granted immediately.
- Second dc_wr_req while wr_pend=1 -> dc_wr_rdy=0 and br_wr_req=0 until br_wr_resp; then accepted.
- Bridge holds br_rd_rdy=0 for 3 cycles during D_REQ -> br_rd_req/br_rd_addr stable throughout, dc_rd_rdy pulses only in the cycle br_rd_rdy=1.
- resetn low during the 2nd beat of an ICache burst -> all outputs 0 immediately; after release, FSM is in IDLE and wr_pend=0; the next request is served normally.
